main_memory_arbiter: RTL and testbench

Shares one block-level main memory between the instruction cache (read-only) and the data cache (read/write), so the system keeps a single backing store instead of one memory per cache. It sits between the two cache miss interfaces and the main memory. Grants are registered and one transfer is in flight at a time. Simultaneous requests are resolved round-robin, and saturating grant/stall counters are kept for performance measurement.

---
 rtl/main_memory_arbiter_pkg.sv | 22 ++
 rtl/sat_counter.sv | 38 +++
 rtl/main_memory_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_main_memory_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_memory_arbiter_pkg.sv
// Shared definitions for the main memory arbiter.
// Contents:
//   - default widths for block address, cache line and performance counters
//   - arbiter state encoding
//   - grant-id constants used for the round-robin history bit
package main_memory_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 28;
  localparam int DEF_LINE_WIDTH = 128;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INS  = 2'd1,
    GRANT_DATA = 2'd2
  } arb_state_e;

  // Identity of the port that received the most recent grant.
  localparam logic INS  = 1'b0;
  localparam logic DATA = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Ports:
//   clk   - clock
//   clr   - synchronous clear, dominates increment
//   inc   - increment enable for this cycle
//   count - current value; sticks at all-ones instead of wrapping
module sat_counter
  import main_memory_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/main_memory_arbiter.sv
// Arbiter sharing one line-granular main memory between the instruction
// cache (read-only) and the data cache (read/write).
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   INS_MEM_*             - instruction cache miss interface (read request,
//                           address, returned line, stall)
//   DATA_MEM_*            - data cache miss interface (read/write request,
//                           address, write line, returned line, stall)
//   MEM_*                 - main memory port (muxed request, address, write
//                           line, returned line, memory busy)
//   INS_GRANT_COUNT       - completed instruction transfers (saturating)
//   DATA_GRANT_COUNT      - completed data transfers (saturating)
//   STALL_COUNT           - cycles where some request waits ungranted
//                           (saturating)
// One transfer is in flight at a time; ties in IDLE go to the port that was
// not granted last. A transfer ends in the first non-busy cycle after the
// memory has been seen busy, and an IDLE cycle always follows it.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  // instruction cache
  input  logic                  INS_MEM_READ,
  input  logic [ADDR_WIDTH-1:0] INS_MEM_ADDRESS,
  output logic [LINE_WIDTH-1:0] INS_MEM_READ_DATA,
  output logic                  INS_MEM_BUSY_WAIT,
  // data cache
  input  logic                  DATA_MEM_READ,
  input  logic                  DATA_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] DATA_MEM_ADDRESS,
  input  logic [LINE_WIDTH-1:0] DATA_MEM_WRITE_DATA,
  output logic [LINE_WIDTH-1:0] DATA_MEM_READ_DATA,
  output logic                  DATA_MEM_BUSY_WAIT,
  // main memory
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [LINE_WIDTH-1:0] MEM_WRITE_DATA,
  input  logic [LINE_WIDTH-1:0] MEM_READ_DATA,
  input  logic                  MEM_BUSY_WAIT,
  // performance counters
  output logic [CNT_WIDTH-1:0]  INS_GRANT_COUNT,
  output logic [CNT_WIDTH-1:0]  DATA_GRANT_COUNT,
  output logic [CNT_WIDTH-1:0]  STALL_COUNT
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_grant_q;
  logic       last_grant_d;
  logic       seen_busy_q;
  logic       seen_busy_d;

  logic ins_req;
  logic data_req;
  logic grant_ins;
  logic grant_data;
  logic complete;
  logic ins_done;
  logic data_done;
  logic stall;

  assign ins_req    = INS_MEM_READ;
  assign data_req   = DATA_MEM_READ | DATA_MEM_WRITE;
  assign grant_ins  = (state_q == GRANT_INS);
  assign grant_data = (state_q == GRANT_DATA);

  // The memory must first have been observed busy, otherwise the idle
  // MEM_BUSY_WAIT in the grant entry cycle would look like a finished transfer.
  assign complete  = (grant_ins | grant_data) && seen_busy_q && !MEM_BUSY_WAIT;
  assign ins_done  = grant_ins && complete;
  assign data_done = grant_data && complete;

  // Both ports waiting in the same cycle still count as a single stall cycle.
  assign stall = (ins_req && !grant_ins) || (data_req && !grant_data);

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    seen_busy_d  = seen_busy_q;
    case (state_q)
      IDLE: begin
        seen_busy_d = 1'b0;
        if (ins_req && data_req) begin
          if (last_grant_q == INS) begin
            state_d      = GRANT_DATA;
            last_grant_d = DATA;
          end else begin
            state_d      = GRANT_INS;
            last_grant_d = INS;
          end
        end else if (ins_req) begin
          state_d      = GRANT_INS;
          last_grant_d = INS;
        end else if (data_req) begin
          state_d      = GRANT_DATA;
          last_grant_d = DATA;
        end
      end
      GRANT_INS, GRANT_DATA: begin
        if (complete) begin
          state_d     = IDLE;
          seen_busy_d = 1'b0;
        end else if (MEM_BUSY_WAIT) begin
          seen_busy_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        seen_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= INS;
      seen_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      seen_busy_q  <= seen_busy_d;
    end
  end

  // Memory-side mux; everything is zero while idle. The request is withdrawn
  // in the completion cycle so the memory does not start a second access.
  always_comb begin
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;
    case (state_q)
      GRANT_INS: begin
        MEM_READ    = INS_MEM_READ && !complete;
        MEM_ADDRESS = INS_MEM_ADDRESS;
      end
      GRANT_DATA: begin
        // A simultaneous read and write is treated as a write-back.
        MEM_WRITE      = DATA_MEM_WRITE && !complete;
        MEM_READ       = DATA_MEM_READ && !DATA_MEM_WRITE && !complete;
        MEM_ADDRESS    = DATA_MEM_ADDRESS;
        MEM_WRITE_DATA = DATA_MEM_WRITE_DATA;
      end
      default: begin
      end
    endcase
  end

  assign INS_MEM_BUSY_WAIT  = ins_req && !ins_done;
  assign DATA_MEM_BUSY_WAIT = data_req && !data_done;
  assign INS_MEM_READ_DATA  = MEM_READ_DATA;
  assign DATA_MEM_READ_DATA = MEM_READ_DATA;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ins_cnt (
    .clk   (CLK),
    .clr   (RESET),
    .inc   (ins_done),
    .count (INS_GRANT_COUNT)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_data_cnt (
    .clk   (CLK),
    .clr   (RESET),
    .inc   (data_done),
    .count (DATA_GRANT_COUNT)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RESET),
    .inc   (stall),
    .count (STALL_COUNT)
  );

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Self-checking bench for main_memory_arbiter: latency-programmable memory
// model, per-port drivers and a scoreboard of expected memory transactions
// and returned lines.
module tb_main_memory_arbiter;

  localparam int AW      = 28;
  localparam int LW      = 128;
  localparam int CW      = 32;
  localparam int MEM_LAT = 5;
  localparam int BUDGET  = 100;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          INS_MEM_READ;
  logic [AW-1:0] INS_MEM_ADDRESS;
  logic [LW-1:0] INS_MEM_READ_DATA;
  logic          INS_MEM_BUSY_WAIT;
  logic          DATA_MEM_READ;
  logic          DATA_MEM_WRITE;
  logic [AW-1:0] DATA_MEM_ADDRESS;
  logic [LW-1:0] DATA_MEM_WRITE_DATA;
  logic [LW-1:0] DATA_MEM_READ_DATA;
  logic          DATA_MEM_BUSY_WAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [LW-1:0] MEM_WRITE_DATA;
  logic [LW-1:0] MEM_READ_DATA;
  logic          MEM_BUSY_WAIT;
  logic [CW-1:0] INS_GRANT_COUNT;
  logic [CW-1:0] DATA_GRANT_COUNT;
  logic [CW-1:0] STALL_COUNT;

  always #5 CLK = ~CLK;

  main_memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .INS_MEM_READ        (INS_MEM_READ),
    .INS_MEM_ADDRESS     (INS_MEM_ADDRESS),
    .INS_MEM_READ_DATA   (INS_MEM_READ_DATA),
    .INS_MEM_BUSY_WAIT   (INS_MEM_BUSY_WAIT),
    .DATA_MEM_READ       (DATA_MEM_READ),
    .DATA_MEM_WRITE      (DATA_MEM_WRITE),
    .DATA_MEM_ADDRESS    (DATA_MEM_ADDRESS),
    .DATA_MEM_WRITE_DATA (DATA_MEM_WRITE_DATA),
    .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
    .DATA_MEM_BUSY_WAIT  (DATA_MEM_BUSY_WAIT),
    .MEM_READ            (MEM_READ),
    .MEM_WRITE           (MEM_WRITE),
    .MEM_ADDRESS         (MEM_ADDRESS),
    .MEM_WRITE_DATA      (MEM_WRITE_DATA),
    .MEM_READ_DATA       (MEM_READ_DATA),
    .MEM_BUSY_WAIT       (MEM_BUSY_WAIT),
    .INS_GRANT_COUNT     (INS_GRANT_COUNT),
    .DATA_GRANT_COUNT    (DATA_GRANT_COUNT),
    .STALL_COUNT         (STALL_COUNT)
  );

  int n_vec    = 0;
  int n_miscmp = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [27:0] a);
    return {4'hC, a, 4'h3, ~a, 4'h5, a, 4'hA, ~a};
  endfunction

  // Memory model: busy for MEM_LAT cycles starting in the first cycle the
  // request is seen, then one non-busy cycle carrying the read line.
  int            mem_cnt = 0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;

  initial begin
    MEM_BUSY_WAIT = 1'b0;
    MEM_READ_DATA = '0;
    forever begin
      @(posedge CLK);
      #2;
      MEM_READ_DATA = '0;
      if (mem_cnt == 0) begin
        if (MEM_READ || MEM_WRITE) begin
          mem_cnt       = 1;
          mem_addr      = MEM_ADDRESS;
          mem_rd        = MEM_READ;
          MEM_BUSY_WAIT = 1'b1;
        end else begin
          MEM_BUSY_WAIT = 1'b0;
        end
      end else if (!(MEM_READ || MEM_WRITE)) begin
        mem_cnt       = 0;
        MEM_BUSY_WAIT = 1'b0;
      end else if (mem_cnt < MEM_LAT) begin
        mem_cnt++;
        MEM_BUSY_WAIT = 1'b1;
      end else begin
        mem_cnt       = 0;
        MEM_BUSY_WAIT = 1'b0;
        if (mem_rd) MEM_READ_DATA = line_of(mem_addr);
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic          rd;
    logic [LW-1:0] line;
  } data_exp_t;

  mem_exp_t      mem_q[$];
  logic [LW-1:0] ins_q[$];
  data_exp_t     data_q[$];

  logic      mem_prev       = 1'b0;
  logic      data_done_prev = 1'b0;
  int        ins_done_cyc   = 0;
  int        data_done_cyc  = 0;
  int        stall_after_data = 0;
  mem_exp_t  me;
  data_exp_t de;

  initial begin
    forever begin
      @(negedge CLK);
      if ((MEM_READ || MEM_WRITE) && !mem_prev) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", 128'(MEM_ADDRESS), 128'(mem_q.size()));
        end else begin
          me = mem_q.pop_front();
          $display("mem xfer rd=%0d wr=%0d addr=%07h wdata=%032h", MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITE_DATA);
          check("mem_wr", 128'(MEM_WRITE), 128'(me.wr));
          check("mem_rd", 128'(MEM_READ), 128'(me.rd));
          check("mem_addr", 128'(MEM_ADDRESS), 128'(me.addr));
          check("mem_wdata", MEM_WRITE_DATA, me.wdata);
        end
      end
      mem_prev = MEM_READ || MEM_WRITE;

      if (data_done_prev) stall_after_data = int'(STALL_COUNT);
      data_done_prev = 1'b0;

      if (INS_MEM_READ && !INS_MEM_BUSY_WAIT) begin
        ins_done_cyc = cyc;
        $display("ins done addr=%07h line=%032h", INS_MEM_ADDRESS, INS_MEM_READ_DATA);
        if (ins_q.size() == 0) check("ins_unexpected", 128'(INS_MEM_ADDRESS), 128'(ins_q.size()));
        else check("ins_rdata", INS_MEM_READ_DATA, ins_q.pop_front());
      end
      if ((DATA_MEM_READ || DATA_MEM_WRITE) && !DATA_MEM_BUSY_WAIT) begin
        data_done_cyc  = cyc;
        data_done_prev = 1'b1;
        $display("data done addr=%07h line=%032h", DATA_MEM_ADDRESS, DATA_MEM_READ_DATA);
        if (data_q.size() == 0) begin
          check("data_unexpected", 128'(DATA_MEM_ADDRESS), 128'(data_q.size()));
        end else begin
          de = data_q.pop_front();
          if (de.rd) check("data_rdata", DATA_MEM_READ_DATA, de.line);
        end
      end
    end
  end

  // Drivers: requests change at posedge+1, completion is polled at negedge.
  task automatic wait_done(input bit is_ins, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < BUDGET && !ok) begin
      @(negedge CLK);
      t++;
      if (is_ins) ok = INS_MEM_READ && !INS_MEM_BUSY_WAIT;
      else        ok = (DATA_MEM_READ || DATA_MEM_WRITE) && !DATA_MEM_BUSY_WAIT;
    end
  endtask

  task automatic ins_xfer(input int n, input logic [AW-1:0] base);
    bit ok;
    for (int k = 0; k < n; k++) begin
      INS_MEM_ADDRESS = base + AW'(k);
      INS_MEM_READ    = 1'b1;
      ins_q.push_back(line_of(base + AW'(k)));
      wait_done(1'b1, ok);
      check("ins_xfer_done", 128'(ok), 128'(1));
      @(posedge CLK);
      #1;
    end
    INS_MEM_READ = 1'b0;
  endtask

  task automatic data_xfer(input int n, input logic [AW-1:0] base, input logic rd,
                           input logic wr, input logic [LW-1:0] wd);
    bit        ok;
    data_exp_t e;
    for (int k = 0; k < n; k++) begin
      DATA_MEM_ADDRESS    = base + AW'(k);
      DATA_MEM_WRITE_DATA = wd;
      DATA_MEM_READ       = rd;
      DATA_MEM_WRITE      = wr;
      e.rd   = rd && !wr;
      e.line = line_of(base + AW'(k));
      data_q.push_back(e);
      wait_done(1'b0, ok);
      check("data_xfer_done", 128'(ok), 128'(1));
      @(posedge CLK);
      #1;
    end
    DATA_MEM_READ  = 1'b0;
    DATA_MEM_WRITE = 1'b0;
  endtask

  task automatic push_mem(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    mem_exp_t e;
    e.wr = wr; e.rd = rd; e.addr = a; e.wdata = wd;
    mem_q.push_back(e);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  int s;
  int nb;

  initial begin
    RESET               = 1'b1;
    INS_MEM_READ        = 1'b0;
    INS_MEM_ADDRESS     = '0;
    DATA_MEM_READ       = 1'b0;
    DATA_MEM_WRITE      = 1'b0;
    DATA_MEM_ADDRESS    = '0;
    DATA_MEM_WRITE_DATA = '0;

    // Reset state; a request during reset only shows up as busy.
    @(posedge CLK);
    #1;
    INS_MEM_READ = 1'b1;
    @(negedge CLK);
    check("rst_mem_read", 128'(MEM_READ), 128'(0));
    check("rst_mem_write", 128'(MEM_WRITE), 128'(0));
    check("rst_mem_addr", 128'(MEM_ADDRESS), 128'(0));
    check("rst_mem_wdata", MEM_WRITE_DATA, 128'(0));
    check("rst_ins_cnt", 128'(INS_GRANT_COUNT), 128'(0));
    check("rst_data_cnt", 128'(DATA_GRANT_COUNT), 128'(0));
    check("rst_stall_cnt", 128'(STALL_COUNT), 128'(0));
    check("rst_ins_busy", 128'(INS_MEM_BUSY_WAIT), 128'(1));
    check("rst_data_busy", 128'(DATA_MEM_BUSY_WAIT), 128'(0));
    @(posedge CLK);
    #1;
    INS_MEM_READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Instruction read alone
    push_mem(1'b0, 1'b1, 28'h0000010, '0);
    fork
      ins_xfer(1, 28'h0000010);
      begin
        s = cyc;
        @(negedge CLK);
        check("t1_idle_mem_read", 128'(MEM_READ), 128'(0));
        check("t1_ins_busy", 128'(INS_MEM_BUSY_WAIT), 128'(1));
        @(negedge CLK);
        check("t1_grant_mem_read", 128'(MEM_READ), 128'(1));
        check("t1_grant_addr", 128'(MEM_ADDRESS), 128'(28'h0000010));
      end
    join
    check("t1_done_latency", 128'(ins_done_cyc - s), 128'(6));
    @(negedge CLK);
    check("t1_ins_cnt", 128'(INS_GRANT_COUNT), 128'(1));
    check("t1_stall_cnt", 128'(STALL_COUNT), 128'(1));
    @(posedge CLK);
    #1;

    // Data write alone
    push_mem(1'b1, 1'b0, 28'h00000A3, 128'hDEADBEEF);
    fork
      data_xfer(1, 28'h00000A3, 1'b0, 1'b1, 128'hDEADBEEF);
      begin
        @(negedge CLK);
        @(negedge CLK);
        check("t2_mem_write", 128'(MEM_WRITE), 128'(1));
        check("t2_mem_read", 128'(MEM_READ), 128'(0));
      end
    join
    @(negedge CLK);
    check("t2_data_cnt", 128'(DATA_GRANT_COUNT), 128'(1));
    check("t2_idle_addr", 128'(MEM_ADDRESS), 128'(0));
    check("t2_idle_wdata", MEM_WRITE_DATA, 128'(0));
    @(posedge CLK);
    #1;

    // Simultaneous requests right after reset: DATA first
    do_reset();
    push_mem(1'b0, 1'b1, 28'h0000030, '0);
    push_mem(1'b0, 1'b1, 28'h0000020, '0);
    fork
      ins_xfer(1, 28'h0000020);
      data_xfer(1, 28'h0000030, 1'b1, 1'b0, '0);
    join
    check("t3_stall_after_data", 128'(stall_after_data), 128'(7));
    check("t3_ins_after_data", 128'(ins_done_cyc - data_done_cyc), 128'(7));
    @(negedge CLK);
    check("t3_ins_cnt", 128'(INS_GRANT_COUNT), 128'(1));
    check("t3_data_cnt", 128'(DATA_GRANT_COUNT), 128'(1));
    @(posedge CLK);
    #1;

    // Fairness: D, I, D, I
    do_reset();
    push_mem(1'b0, 1'b1, 28'h0000100, '0);
    push_mem(1'b0, 1'b1, 28'h0000200, '0);
    push_mem(1'b0, 1'b1, 28'h0000101, '0);
    push_mem(1'b0, 1'b1, 28'h0000201, '0);
    fork
      ins_xfer(2, 28'h0000200);
      data_xfer(2, 28'h0000100, 1'b1, 1'b0, '0);
    join
    @(negedge CLK);
    check("t4_ins_cnt", 128'(INS_GRANT_COUNT), 128'(2));
    check("t4_data_cnt", 128'(DATA_GRANT_COUNT), 128'(2));
    @(posedge CLK);
    #1;

    // Reset on the 3rd busy cycle of a data read
    push_mem(1'b0, 1'b1, 28'h0000055, '0);
    push_mem(1'b0, 1'b1, 28'h0000055, '0);
    fork
      data_xfer(1, 28'h0000055, 1'b1, 1'b0, '0);
      begin
        nb = 0;
        for (int t = 0; t < BUDGET && nb < 3; t++) begin
          @(negedge CLK);
          if (MEM_READ && MEM_BUSY_WAIT) nb++;
        end
        check("t5_busy_seen", 128'(nb), 128'(3));
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("t5_mem_read", 128'(MEM_READ), 128'(0));
        check("t5_data_cnt", 128'(DATA_GRANT_COUNT), 128'(0));
        check("t5_ins_cnt", 128'(INS_GRANT_COUNT), 128'(0));
        check("t5_stall_cnt", 128'(STALL_COUNT), 128'(0));
        check("t5_data_busy", 128'(DATA_MEM_BUSY_WAIT), 128'(1));
      end
    join
    @(negedge CLK);
    check("t5_regrant_cnt", 128'(DATA_GRANT_COUNT), 128'(1));

    // Read+write together is a write; saturated counter holds
    force dut.u_data_cnt.count_q = '1;
    @(posedge CLK);
    @(negedge CLK);
    release dut.u_data_cnt.count_q;
    @(posedge CLK);
    #1;
    push_mem(1'b1, 1'b0, 28'h0000077, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    data_xfer(1, 28'h0000077, 1'b1, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    @(negedge CLK);
    check("t6_data_cnt_sat", 128'(DATA_GRANT_COUNT), 128'(32'hFFFF_FFFF));

    check("sb_mem_left", 128'(mem_q.size()), 128'(0));
    check("sb_ins_left", 128'(ins_q.size()), 128'(0));
    check("sb_data_left", 128'(data_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
